// File: rtl/pool_engine.sv
// pool_engine: 2-D max/average pooling over all channels of a feature map
// held in a synchronous-read memory; one result written per window.
module pool_engine #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned IN_H     = 26,
  parameter int unsigned IN_W     = 26,
  parameter int unsigned WIN      = 2,
  parameter int unsigned STRIDE   = 2,
  localparam int unsigned OUT_H    = (IN_H - WIN) / STRIDE + 1,
  localparam int unsigned OUT_W    = (IN_W - WIN) / STRIDE + 1,
  localparam int unsigned RD_DEPTH = CHANNELS * IN_H * IN_W,
  localparam int unsigned WR_DEPTH = CHANNELS * OUT_H * OUT_W,
  localparam int unsigned RA_W     = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1,
  localparam int unsigned WA_W     = (WR_DEPTH > 1) ? $clog2(WR_DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [RA_W-1:0]          rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic                     wr_en,
  output logic [WA_W-1:0]          wr_addr,
  output logic signed [DATA_W-1:0] wr_data
);

  localparam int unsigned C_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned OY_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned OX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned K_W   = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned SHIFT = 2 * $clog2(WIN);
  localparam int unsigned ACC_W = DATA_W + SHIFT;

  localparam logic [C_W-1:0]  C_LAST  = C_W'(CHANNELS - 1);
  localparam logic [OY_W-1:0] OY_LAST = OY_W'(OUT_H - 1);
  localparam logic [OX_W-1:0] OX_LAST = OX_W'(OUT_W - 1);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(WIN - 1);

  typedef enum logic [2:0] {
    IDLE, READ, LAST, WRITE, DONE, WAIT_START_LOW
  } state_t;

  state_t                    state;
  logic                      mode_q;
  logic                      seeded;
  logic [C_W-1:0]            c;
  logic [OY_W-1:0]           oy;
  logic [OX_W-1:0]           ox;
  logic [K_W-1:0]            ky;
  logic [K_W-1:0]            kx;
  logic signed [ACC_W-1:0]   acc;

  logic [C_W-1:0]            nx_c;
  logic [OY_W-1:0]           nx_oy;
  logic [OX_W-1:0]           nx_ox;
  logic [K_W-1:0]            nx_ky;
  logic [K_W-1:0]            nx_kx;
  logic                      last_win;
  logic                      last_k;
  logic signed [ACC_W-1:0]   x_ext;
  logic signed [ACC_W-1:0]   acc_nx;
  logic signed [ACC_W-1:0]   avg_res;
  logic signed [DATA_W-1:0]  result;

  function automatic logic [RA_W-1:0] rd_addr_of(input int unsigned fc, input int unsigned fy,
                                                 input int unsigned fx, input int unsigned fky,
                                                 input int unsigned fkx);
    int unsigned a;
    a = fc * IN_H * IN_W + (fy * STRIDE + fky) * IN_W + fx * STRIDE + fkx;
    return RA_W'(a);
  endfunction

  function automatic logic [WA_W-1:0] wr_addr_of(input int unsigned fc, input int unsigned fy,
                                                 input int unsigned fx);
    int unsigned a;
    a = fc * OUT_H * OUT_W + fy * OUT_W + fx;
    return WA_W'(a);
  endfunction

  // Next window (ox fastest, then oy, then c) and next kernel tap (kx fastest).
  always_comb begin
    nx_c     = c;
    nx_oy    = oy;
    nx_ox    = ox;
    nx_ky    = ky;
    nx_kx    = kx;
    last_win = (c == C_LAST) && (oy == OY_LAST) && (ox == OX_LAST);
    last_k   = (ky == K_LAST) && (kx == K_LAST);
    if (ox != OX_LAST) begin
      nx_ox = ox + OX_W'(1);
    end else begin
      nx_ox = '0;
      if (oy != OY_LAST) begin
        nx_oy = oy + OY_W'(1);
      end else begin
        nx_oy = '0;
        nx_c  = c + C_W'(1);
      end
    end
    if (kx != K_LAST) begin
      nx_kx = kx + K_W'(1);
    end else begin
      nx_kx = '0;
      nx_ky = ky + K_W'(1);
    end
  end

  // Fold the element on rd_data into the running max / sum; first element seeds.
  always_comb begin
    x_ext  = ACC_W'(rd_data);
    acc_nx = acc;
    if (!seeded) begin
      acc_nx = x_ext;
    end else if (!mode_q) begin
      acc_nx = (x_ext > acc) ? x_ext : acc;
    end else begin
      acc_nx = acc + x_ext;
    end
    avg_res = acc_nx >>> SHIFT;
    result  = mode_q ? DATA_W'(avg_res) : DATA_W'(acc_nx);
  end

  // Pass sequencer with registered memory strobes, addresses and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      seeded  <= 1'b0;
      c       <= '0;
      oy      <= '0;
      ox      <= '0;
      ky      <= '0;
      kx      <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      done  <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q  <= mode;
            c       <= '0;
            oy      <= '0;
            ox      <= '0;
            ky      <= '0;
            kx      <= '0;
            seeded  <= 1'b0;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= rd_addr_of(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
            state   <= READ;
          end
        end
        READ: begin
          if (kx != '0 || ky != '0) begin
            acc    <= acc_nx;
            seeded <= 1'b1;
          end
          if (last_k) begin
            rd_en <= 1'b0;
            state <= LAST;
          end else begin
            kx      <= nx_kx;
            ky      <= nx_ky;
            rd_addr <= rd_addr_of(32'(c), 32'(oy), 32'(ox), 32'(nx_ky), 32'(nx_kx));
          end
        end
        LAST: begin
          wr_data <= result;
          wr_addr <= wr_addr_of(32'(c), 32'(oy), 32'(ox));
          wr_en   <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          if (last_win) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            c       <= nx_c;
            oy      <= nx_oy;
            ox      <= nx_ox;
            ky      <= '0;
            kx      <= '0;
            seeded  <= 1'b0;
            rd_en   <= 1'b1;
            rd_addr <= rd_addr_of(32'(nx_c), 32'(nx_oy), 32'(nx_ox), 32'd0, 32'd0);
            state   <= READ;
          end
        end
        DONE: begin
          state <= WAIT_START_LOW;
        end
        WAIT_START_LOW: begin
          if (!start) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// tb_pool_engine: directed checks of pool_engine at default size and a small
// overlapping-window configuration.
module tb_pool_engine;

  localparam int unsigned D_DEPTH = 16 * 26 * 26;
  localparam int unsigned D_NWIN  = 16 * 13 * 13;
  localparam int unsigned O_DEPTH = 2 * 3 * 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_d, mode_d, start_o, mode_o;

  logic                busy_d, done_d, rd_en_d, wr_en_d;
  logic [13:0]         rd_addr_d;
  logic [11:0]         wr_addr_d;
  logic signed [31:0]  rd_data_d, wr_data_d;

  logic                busy_o, done_o, rd_en_o, wr_en_o;
  logic [4:0]          rd_addr_o;
  logic [2:0]          wr_addr_o;
  logic signed [31:0]  rd_data_o, wr_data_o;

  pool_engine u_dflt (
    .clk(clk), .reset(reset), .start(start_d), .mode(mode_d),
    .busy(busy_d), .done(done_d), .rd_en(rd_en_d), .rd_addr(rd_addr_d),
    .rd_data(rd_data_d), .wr_en(wr_en_d), .wr_addr(wr_addr_d), .wr_data(wr_data_d)
  );

  pool_engine #(.CHANNELS(2), .IN_H(3), .IN_W(3), .WIN(2), .STRIDE(1)) u_ovl (
    .clk(clk), .reset(reset), .start(start_o), .mode(mode_o),
    .busy(busy_o), .done(done_o), .rd_en(rd_en_o), .rd_addr(rd_addr_o),
    .rd_data(rd_data_o), .wr_en(wr_en_o), .wr_addr(wr_addr_o), .wr_data(wr_data_o)
  );

  int mem_d [D_DEPTH];
  int mem_o [O_DEPTH];
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  int wa_d[$];
  int wd_d[$];
  int ra_o[$];
  int wa_o[$];
  int wd_o[$];
  int oob_d = 0;
  int act_d = 0;

  // Synchronous-read memories: data appears the cycle after rd_en.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en_d) rd_data_d <= mem_d[rd_addr_d];
    if (rd_en_o) rd_data_o <= mem_o[rd_addr_o];
  end

  // Log memory traffic away from the active edge.
  always @(negedge clk) begin
    if (wr_en_d) begin
      wa_d.push_back(32'(wr_addr_d));
      wd_d.push_back(int'(wr_data_d));
    end
    if (rd_en_d && 32'(rd_addr_d) >= D_DEPTH) oob_d <= oob_d + 1;
    if (rd_en_d || wr_en_d) act_d <= act_d + 1;
    if (rd_en_o) ra_o.push_back(32'(rd_addr_o));
    if (wr_en_o) begin
      wa_o.push_back(32'(wr_addr_o));
      wd_o.push_back(int'(wr_data_o));
    end
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint pool4(input longint a, input longint b, input longint c,
                                   input longint d, input bit m);
    longint mx;
    if (m) return (a + b + c + d) >>> 2;
    mx = a;
    if (b > mx) mx = b;
    if (c > mx) mx = c;
    if (d > mx) mx = d;
    return mx;
  endfunction

  task automatic start_pass_d(input logic m, output int t0);
    bit got;
    got = 1'b0;
    mode_d  = m;
    start_d = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy_d) begin
        got = 1'b1;
        break;
      end
    end
    t0 = cyc;
    check_val("busy_rise", longint'(got), 1);
  endtask

  task automatic wait_done_d(input string tag, output int t1);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done_d) begin
        got = 1'b1;
        break;
      end
    end
    t1 = cyc;
    check_val({tag, "_done_seen"}, longint'(got), 1);
  endtask

  // Compare a whole default-size pass against the window model.
  task automatic check_pass_d(input string tag, input int base, input bit m);
    int n, lim, bad, c, r, oy, ox, a0;
    longint exp;
    n   = wa_d.size() - base;
    lim = (n < int'(D_NWIN)) ? n : int'(D_NWIN);
    bad = 0;
    check_val({tag, "_writes"}, n, D_NWIN);
    for (int i = 0; i < lim; i++) begin
      c   = i / 169;
      r   = i % 169;
      oy  = r / 13;
      ox  = r % 13;
      a0  = c * 676 + oy * 52 + ox * 2;
      exp = pool4(mem_d[a0], mem_d[a0 + 1], mem_d[a0 + 26], mem_d[a0 + 27], m);
      if (wa_d[base + i] != i || longint'(wd_d[base + i]) != exp) bad++;
    end
    check_val({tag, "_bad_windows"}, bad, 0);
  endtask

  int exp_o [8] = '{5, 2, 5, 1, 3, 5, 2, 5};
  int t0, t1, base, snap, nwr, bad, wb;
  bit got;

  initial begin
    reset   = 1'b0;
    start_d = 1'b0;
    mode_d  = 1'b0;
    start_o = 1'b0;
    mode_o  = 1'b0;
    for (int a = 0; a < int'(D_DEPTH); a++) mem_d[a] = a * 3 - 16000;
    for (int a = 0; a < int'(O_DEPTH); a++) mem_o[a] = ((a * 7) % 11) - 5;
    mem_d[0] = -5; mem_d[1] = -3; mem_d[26] = -3; mem_d[27] = -9;
    mem_d[2] = 32'h1000_0007; mem_d[3] = 32'h4000_0003;
    mem_d[28] = 32'h4000_0003; mem_d[29] = 32'h2000_0000;

    repeat (3) @(negedge clk);
    check_val("rst_busy", longint'(busy_d), 0);
    check_val("rst_done", longint'(done_d), 0);
    check_val("rst_rd_en", longint'(rd_en_d), 0);
    check_val("rst_wr_en", longint'(wr_en_d), 0);
    check_val("rst_rd_addr", longint'(rd_addr_d), 0);
    check_val("rst_wr_addr", longint'(wr_addr_d), 0);
    check_val("rst_wr_data", longint'(wr_data_d), 0);
    check_val("rst_ovl_busy", longint'(busy_o | rd_en_o | wr_en_o), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Overlapping 2x2 stride-1 windows on 2x3x3.
    start_o = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1'b1;
        break;
      end
    end
    check_val("ovl_done_seen", longint'(got), 1);
    check_val("ovl_writes", wa_o.size(), 8);
    check_val("ovl_reads", ra_o.size(), 32);
    for (int i = 0; i < 8 && i < wa_o.size(); i++) begin
      check_val($sformatf("ovl_addr%0d", i), wa_o[i], i);
      check_val($sformatf("ovl_data%0d", i), wd_o[i], exp_o[i]);
    end
    bad = 0;
    for (int i = 0; i < 32 && i < ra_o.size(); i++) begin
      wb = (i / 16) * 9 + ((i / 4) % 4 / 2) * 3 + (i / 4) % 2;
      if (ra_o[i] != wb + ((i % 4) / 2) * 3 + (i % 2)) bad++;
    end
    check_val("ovl_rd_pattern", bad, 0);
    start_o = 1'b0;

    // Pass A: max over ramp, with tie windows at (0,0,0) and (0,0,1).
    base = wa_d.size();
    start_pass_d(1'b0, t0);
    wait_done_d("passA", t1);
    check_val("passA_cycles", t1 - t0, 16224);
    @(negedge clk);
    check_val("done_one_cycle", longint'(done_d), 0);
    check_pass_d("passA", base, 1'b0);
    if (wd_d.size() >= base + int'(D_NWIN)) begin
      check_val("tie_first", wd_d[base], -3);
      check_val("tie_marker", wd_d[base + 1], 32'h4000_0003);
      check_val("ramp_w5", wd_d[base + 5], -15889);
      check_val("ramp_last", wd_d[base + 2703], 16445);
    end

    // Held start must not retrigger.
    snap = act_d;
    repeat (100) @(negedge clk);
    check_val("held_start_activity", act_d - snap, 0);
    check_val("held_start_busy", longint'(busy_d), 0);

    // Pass B: average mode sampled on the fresh start.
    start_d = 1'b0;
    repeat (2) @(negedge clk);
    mem_d[0] = -1; mem_d[1] = -2; mem_d[26] = -3; mem_d[27] = -4;
    mem_d[2] = 1; mem_d[3] = 2; mem_d[28] = 3; mem_d[29] = 5;
    mem_d[4] = 32'h7FFF_FFFF; mem_d[5] = 32'h7FFF_FFFF;
    mem_d[30] = 32'h7FFF_FFFF; mem_d[31] = 32'h7FFF_FFFF;
    base = wa_d.size();
    start_pass_d(1'b1, t0);
    mode_d = 1'b0;
    wait_done_d("passB", t1);
    check_val("passB_cycles", t1 - t0, 16224);
    check_pass_d("passB", base, 1'b1);
    if (wd_d.size() >= base + int'(D_NWIN)) begin
      check_val("avg_neg_floor", wd_d[base], -3);
      check_val("avg_pos_floor", wd_d[base + 1], 2);
      check_val("avg_no_ovf", wd_d[base + 2], 32'h7FFF_FFFF);
      check_val("avg_ramp_w5", wd_d[base + 5], -15930);
    end
    check_val("rd_addr_in_range", oob_d, 0);

    // Pass C: reset during the 10th write.
    start_d = 1'b0;
    repeat (2) @(negedge clk);
    mode_d  = 1'b0;
    start_d = 1'b1;
    nwr = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_en_d) nwr++;
      if (nwr == 10) break;
    end
    check_val("tenth_write_seen", nwr, 10);
    reset   = 1'b0;
    start_d = 1'b0;
    #1;
    check_val("midrst_wr_en", longint'(wr_en_d), 0);
    check_val("midrst_rd_en", longint'(rd_en_d), 0);
    check_val("midrst_busy", longint'(busy_d), 0);
    check_val("midrst_wr_addr", longint'(wr_addr_d), 0);
    check_val("midrst_wr_data", longint'(wr_data_d), 0);
    check_val("midrst_rd_addr", longint'(rd_addr_d), 0);
    @(negedge clk);
    reset = 1'b1;
    snap = act_d;
    repeat (50) @(negedge clk);
    check_val("post_rst_quiet", act_d - snap, 0);

    // Pass D: full pass after the aborted one.
    base = wa_d.size();
    start_pass_d(1'b0, t0);
    wait_done_d("passD", t1);
    check_val("passD_cycles", t1 - t0, 16224);
    check_pass_d("passD", base, 1'b0);
    if (wd_d.size() >= base + int'(D_NWIN)) begin
      check_val("passD_addr0", wa_d[base], 0);
      check_val("passD_data0", wd_d[base], -1);
    end
    start_d = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pool_engine.md
Name: pool_engine

Overview:
- Parametrised 2-D pooling engine; successor to the fixed 16x26x26 / 2x2 max-pool stage.
- Reads feature maps from a synchronous memory, pools every channel with a runtime-selectable max or average window, and writes results to an output memory.
- Sits between a conv stage's output buffer and the next layer, under the same start/done handshake used by the rest of the CNN pipeline.

Parameters:
- DATA_W, 32: signed element width.
- CHANNELS, 16: number of feature maps.
- IN_H, 26: input rows.
- IN_W, 26: input columns.
- WIN, 2: square window size; legal values are 1, 2, 4.
- STRIDE, 2: window step; must be >=1.
- Derived: OUT_H=(IN_H-WIN)/STRIDE+1, OUT_W=(IN_W-WIN)/STRIDE+1, RA_W=clog2(CHANNELS*IN_H*IN_W), WA_W=clog2(CHANNELS*OUT_H*OUT_W).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; starts a pass when seen high in IDLE.
- mode  in  1  0 = max, 1 = average; sampled in IDLE when start is seen.
- busy  out  1  high from the first READ cycle through the final WRITE.
- done  out  1  one-cycle pulse at pass completion.
- rd_en  out  1  input memory read strobe.
- rd_addr  out  RA_W  input address = c*IN_H*IN_W + row*IN_W + col.
- rd_data  in  DATA_W  signed; valid the cycle after rd_en.
- wr_en  out  1  output write strobe.
- wr_addr  out  WA_W  output address = c*OUT_H*OUT_W + oy*OUT_W + ox.
- wr_data  out  DATA_W  signed pooled result.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; busy, done, rd_en, wr_en=0; rd_addr, wr_addr, wr_data=0; all counters=0. A reset mid-pass abandons the pass with no further writes.
- States: IDLE, READ, LAST, WRITE, DONE, WAIT_START_LOW.
- IDLE: on start=1, latch mode and go to READ with c=oy=ox=0.
- READ: exactly WIN*WIN consecutive cycles, rd_en=1. The k-th read (ky=k/WIN, kx=k%WIN) addresses row oy*STRIDE+ky, col ox*STRIDE+kx. From the second READ cycle onward, fold the previous rd_data into the accumulator. After the last read, go to LAST.
- LAST: rd_en=0; fold the final rd_data; compute the result into the wr_data register; go to WRITE.
- WRITE: wr_en=1 for one cycle with wr_addr/wr_data. Then advance ox, else oy, else c (ox fastest). After writing (CHANNELS-1, OUT_H-1, OUT_W-1), go to DONE; otherwise go to READ.
- Per-window cost: WIN*WIN+2 cycles. Total = CHANNELS*OUT_H*OUT_W*(WIN*WIN+2) cycles. Defaults: 2704 windows x 6 = 16224 cycles.
- Max mode:
  - Signed compare; the first window element seeds the running max.
  - Replace only on strictly greater, so ties keep the earlier element.
- Average mode:
  - Accumulator is DATA_W+2*log2(WIN) bits, sign-extended adds, no overflow possible.
  - Result = acc >>> 2*log2(WIN) (arithmetic shift, floor toward -inf), truncated to DATA_W.
  - WIN=1 passes data through unchanged.
- DONE: done=1 for exactly one cycle; busy drops in this cycle. Next state is WAIT_START_LOW.
- WAIT_START_LOW: stay until start=0, then go to IDLE. A held start never retriggers a pass.
- start and mode changes while busy are ignored.
- Each output address is written exactly once per pass. No input address is read outside [0, CHANNELS*IN_H*IN_W-1].
- Partial windows are never formed; rows/cols beyond the last full window are skipped.

Test Plan:
- Defaults, mode=0, rd_data = signed address-dependent ramp -> 2704 writes; element (c,oy,ox) equals the bottom-right input of its window. done pulses at cycle 16224 after the first READ.
- Defaults, mode=0, window {-5,-3,-3,-9} (tie) -> wr_data=-3. Confirm the first occurrence is kept via a marker in the upper bits of a second tie test.
- WIN=2, mode=1, window {-1,-2,-3,-4} -> -3 (floor of -2.5). Window {1,2,3,5} -> 2. Window {0x7FFFFFFF x4} -> 0x7FFFFFFF, no overflow.
- CHANNELS=2, IN_H=IN_W=3, WIN=2, STRIDE=1 (overlap) -> 8 writes, addresses 0..7. Read addresses per window follow {base, base+1, base+3, base+4}.
- start held high for 100 cycles after done -> no second pass. Drop start, raise start -> a new pass runs with the newly sampled mode.
- reset asserted during the 10th WRITE -> all outputs 0 immediately and no writes until the next start. The next pass completes correctly from address 0.
